// File: rtl/janus_pkg.sv
// janus_pkg: shared defaults and helpers for the fetch/decode path.
// Holds instruction queue sizing defaults and the occupancy-width helper.
package janus_pkg;

  localparam int PA_DATA_WIDTH_DEF = 32;
  localparam int PA_DEPTH_DEF      = 4;

  // Occupancy counter needs one more bit than a pointer to encode "full".
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_parity_gen.sv
// iq_parity_gen: reduction-XOR parity of one instruction word.
// Used on the write side to generate and on the read side to check.
module iq_parity_gen #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  output logic         par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/inst_queue.sv
// inst_queue: show-ahead instruction queue between fetch and decode.
// Optional per-entry parity is enabled with INST_QUEUE_PARITY_EN.
module inst_queue
  import janus_pkg::*;
#(
  parameter  int PA_DATA_WIDTH = PA_DATA_WIDTH_DEF,
  parameter  int PA_DEPTH      = PA_DEPTH_DEF,
  localparam int PA_PTR_WIDTH  = $clog2(PA_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [PA_DATA_WIDTH-1:0] data_in,
  input  logic                     ir_wr,
  output logic                     ir_wr_ack,
  output logic                     ir_full,
  output logic                     ir_valid,
  output logic [PA_DATA_WIDTH-1:0] data_out,
  input  logic                     ir_rd,
  input  logic                     flush,
`ifdef INST_QUEUE_PARITY_EN
  output logic [PA_PTR_WIDTH:0]    count,
  output logic                     par_err
`else
  output logic [PA_PTR_WIDTH:0]    count
`endif
);

  localparam int CNT_W = occ_width(PA_DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PA_DEPTH);

  logic [PA_DATA_WIDTH-1:0] mem_q [PA_DEPTH];

  logic [PA_PTR_WIDTH-1:0] wr_ptr_q;
  logic [PA_PTR_WIDTH-1:0] wr_ptr_d;
  logic [PA_PTR_WIDTH-1:0] rd_ptr_q;
  logic [PA_PTR_WIDTH-1:0] rd_ptr_d;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic                    ack_q;

  logic wr_acc;
  logic rd_acc;

  // Status flags come from registered count only, so a
  // same-cycle pop never makes room for a write.
  assign ir_full  = (count_q == FULL_CNT);
  assign ir_valid = (count_q != '0);
  assign count    = count_q;
  assign ir_wr_ack = ack_q;

  // Flush wins over both ports.
  assign wr_acc = ir_wr && !ir_full && !flush;
  assign rd_acc = ir_rd && ir_valid && !flush;

  // Show-ahead head entry; stale but deterministic when empty.
  assign data_out = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and acknowledge registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= wr_acc;
    end
  end

  // Entry storage; flush leaves contents in place.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < PA_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef INST_QUEUE_PARITY_EN

  logic [PA_DEPTH-1:0] par_q;
  logic                wr_par;
  logic                chk_par;

  iq_parity_gen #(
    .W (PA_DATA_WIDTH)
  ) u_wr_par (
    .data_i (data_in),
    .par_o  (wr_par)
  );

  iq_parity_gen #(
    .W (PA_DATA_WIDTH)
  ) u_chk_par (
    .data_i (data_out),
    .par_o  (chk_par)
  );

  // Parity bit captured alongside each accepted write.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      par_q <= '0;
    end else if (wr_acc) begin
      par_q[wr_ptr_q] <= wr_par;
    end
  end

  assign par_err = ir_valid && (par_q[rd_ptr_q] != chk_par);

`endif

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised instruction queue: stores up to PA_DEPTH fetched instructions between the memory fetch path and the decoder. It replaces the single-entry instruction register and keeps the same write-request / one-cycle-acknowledge style on the fetch side. It adds a show-ahead read port, flush, occupancy reporting and optional per-entry parity.

## Interface
- PA_DATA_WIDTH, 32, instruction width in bits
- PA_DEPTH, 4, number of entries; power of two, ≥ 2
- PA_PTR_WIDTH, $clog2(PA_DEPTH), pointer width; derived, not overridden
- clk  in  1  rising-edge clock; the block's only clock
- rst_b  in  1  asynchronous, active-low reset
- data_in  in  PA_DATA_WIDTH  instruction from the fetch path
- ir_wr  in  1  write request; sampled every cycle
- ir_wr_ack  out  1  one-cycle pulse, the cycle after a write is accepted
- ir_full  out  1  count == PA_DEPTH
- ir_valid  out  1  count != 0; head entry is meaningful
- data_out  out  PA_DATA_WIDTH  head entry, mem[rd_ptr], show-ahead
- ir_rd  in  1  pop head entry
- flush  in  1  discard all entries
- count  out  PA_PTR_WIDTH+1  current occupancy
- par_err  out  1  head parity mismatch; port exists only with INST_QUEUE_PARITY_EN

## Operation
- Reset values:
  - wr_ptr, rd_ptr, count, ir_wr_ack and all mem entries = 0.
  - Hence ir_valid=0, ir_full=0, data_out=0 and par_err=0.
- Write accept: ir_wr && !ir_full && !flush.
  - mem[wr_ptr] <= data_in; wr_ptr increments.
  - ir_wr_ack = 1 on the next cycle only.
  - ir_wr held high writes every cycle until the queue is full.
- Write while full: dropped; no ack; contents unchanged. ir_full uses the registered count, so a same-cycle pop does not make room.
- Read accept: ir_rd && ir_valid && !flush; rd_ptr increments. ir_rd while empty is ignored.
- Simultaneous accepted write and read: both pointers advance; count unchanged.
- Flush has priority over everything:
  - next cycle wr_ptr = rd_ptr = count = 0;
  - a same-cycle write is dropped, with no ack;
  - mem contents are not cleared.
- Pointers wrap from PA_DEPTH-1 to 0 naturally; count saturates in neither direction because full and empty guard it.
- data_out follows rd_ptr combinationally from registered storage. It is stale but deterministic when ir_valid=0.
- Reset mid-operation: all state returns asynchronously to reset values. An ack pending from a write in the previous cycle is lost.

## Timing
- Write-to-visible latency: 1 cycle. A write into an empty queue raises ir_valid in the same cycle as ir_wr_ack.
- Pop latency: data_out shows the next entry in the cycle after an accepted ir_rd.
- Sustained throughput: one write and one read per cycle.
- count, ir_full and ir_valid update one cycle after the event that changes them.
- No combinational path from ir_wr or ir_rd to any output.

## Configuration
- INST_QUEUE_PARITY_EN defined:
  - each entry stores an extra bit, ^data_in, computed at write;
  - par_err = ir_valid && (stored bit != ^data_out), combinational from registered storage;
  - par_err resets to 0.
- INST_QUEUE_PARITY_EN undefined: no parity storage and no par_err port; behaviour otherwise identical.

## Structure
- Shared package janus_pkg holds:
  - the PA_DATA_WIDTH and PA_DEPTH defaults;
  - the occupancy-width helper.
- One sub-module is natural: iq_parity_gen, the reduction-XOR generator used on both write and check. It is instantiated only under INST_QUEUE_PARITY_EN.

## Test plan
- After reset, PA_DEPTH=4: ir_wr=1 with data_in 0xA0..0xA3 for 4 cycles -> ack pulses on cycles 1–4, count 1..4, ir_full=1, data_out=0xA0.
- Full queue, ir_wr with 0xBB -> no ack, count stays 4. Pop 4 times -> data_out sequence 0xA0..0xA3, then ir_valid=0.
- Count=2: write 0xC0 and pop in the same cycle -> count stays 2, ack pulses, head advances. Repeat 6 times to exercise pointer wrap.
- Count=3: assert flush together with ir_wr=0xDD -> next cycle count=0, ir_valid=0, no ack. A subsequent write of 0xEE appears at data_out.
- ir_rd while empty -> no pointer change, count=0. A write issued mid-operation, then rst_b pulsed low -> ack never appears, all outputs 0.
- With INST_QUEUE_PARITY_EN: write 0x00000001, force a flip of the stored parity bit -> par_err=1 while it is head; pop -> par_err=0.
